traffic_light_fsm: RTL and testbench
====================================

# traffic_light_fsm

Two-road intersection controller that consumes the one-second enable pulse from the divider stage and sequences the main-road and side-road lamps. It sits directly downstream of the divider: it counts its pulses per phase and drives the lamp outputs to the board. It also drives the divider's reset input, so the first second after a controller reset is a full second.

## Interface
- `MAIN_GREEN_S`, 20: minimum main-road green, in seconds (1..255)
- `SIDE_GREEN_S`, 10: side-road green, in seconds (1..255)
- `YELLOW_S`, 3: yellow duration for either road (1..255)
- `ALL_RED_S`, 1: all-red clearance after each yellow (1..255)
- `clk`  in  1  system clock
- `controller_reset`  in  1  synchronous, active-high reset; one clock, reset is synchronous and active-high
- `second_tick`  in  1  one-cycle pulse per second, from the divider's `enable_output`
- `side_car`  in  1  side-road vehicle sensor, level, synchronous to `clk`
- `ped_button`  in  1  pedestrian request, level or pulse, synchronous to `clk`
- `main_light`  out  3  one-hot {red, yellow, green}
- `side_light`  out  3  one-hot {red, yellow, green}
- `walk`  out  1  pedestrian walk lamp (crossing the main road)
- `timer_restart`  out  1  to the divider's `devider_reset`

## Operation
- Phases: MAIN_GREEN → MAIN_YELLOW → ALL_RED_A → SIDE_GREEN → SIDE_YELLOW → ALL_RED_B → MAIN_GREEN.
- Phase counter `phase_cnt` is 8 bits. It increments only on `second_tick`. It clears to 0 on every phase change.
- A phase with duration D ends on the `second_tick` seen while `phase_cnt == D-1`. The state advances on that edge and `phase_cnt` becomes 0.
- MAIN_GREEN exit condition: `phase_cnt == MAIN_GREEN_S-1` and `second_tick` and (`side_car` or `ped_req`).
  - If the condition fails, `phase_cnt` saturates at `MAIN_GREEN_S-1` and the state holds.
  - MAIN_GREEN is therefore left on the first tick at which a request is present.
- `ped_req` latch:
  - Set by `ped_button`.
  - Cleared on entry to SIDE_GREEN.
  - If set and clear occur in the same cycle, set wins.
- `walk` = 1 only in SIDE_GREEN while the request that caused the cycle was latched. That request is captured into `walk_en` on entry to SIDE_GREEN.
- Lamps are Moore outputs decoded from the state register:
  - main: green in MAIN_GREEN, yellow in MAIN_YELLOW, red otherwise.
  - side: green in SIDE_GREEN, yellow in SIDE_YELLOW, red otherwise.
- Reset values: state = MAIN_GREEN; `phase_cnt` = 0; `ped_req` = 0; `walk_en` = 0.
  - `main_light` = 001, `side_light` = 100, `walk` = 0.
- `timer_restart` is a register loaded with `controller_reset`. It is therefore high the cycle after reset is sampled and low one cycle after reset is released.
- Reset mid-phase: the next cycle is MAIN_GREEN with the counter at 0, regardless of the previous state. A pending pedestrian request is discarded.
- `second_tick` asserted during reset is ignored.

## Timing
- Tick sampled in cycle N, phase end → new state and lamps visible in cycle N+1 (one-cycle latency).
- Green and yellow are never both on for any road. No cycle has both roads non-red.
- Back-to-back ticks (tick high in consecutive cycles) each count. The block does not assume tick spacing.

## Configuration
- Macro: `TRAFFIC_PED_REQUEST_EN`.
- Defined: pedestrian latch and `walk` are implemented as described.
- Undefined:
  - `ped_button` is ignored, `ped_req` and `walk_en` are constant 0, and `walk` is tied 0.
  - MAIN_GREEN exit depends on `side_car` only.
  - The ports remain present so the top level is unchanged.

## Structure
- Package `traffic_pkg`:
  - phase enumeration (3-bit encoding, MAIN_GREEN = 0)
  - lamp constants LAMP_RED = 100, LAMP_YELLOW = 010, LAMP_GREEN = 001
  - `PHASE_CNT_W` = 8
- Sub-module `phase_timer`:
  - Holds the 8-bit counter with tick-enable, synchronous clear and saturation.
  - Outputs `expired` = (`phase_cnt == limit-1`) & `second_tick`.
  - Takes `limit` selected by the FSM.
- The FSM and lamp decode stay in `traffic_light_fsm`.

## Test plan
All scenarios use MAIN_GREEN_S=4, SIDE_GREEN_S=3, YELLOW_S=2, ALL_RED_S=1, with `second_tick` every 5 cycles.
- Reset, then 10 ticks with `side_car` = 0 → `main_light` stays 001 and `side_light` 100. `timer_restart` is high exactly the cycle after reset is sampled through one cycle after release.
- `side_car` = 1 from reset → after 4 ticks MAIN_YELLOW, +2 MAIN_YELLOW→ALL_RED_A, +1 SIDE_GREEN, +3 SIDE_YELLOW, +2 ALL_RED_B, +1 MAIN_GREEN. Each change is 1 cycle after its tick.
- `side_car` asserted after 7 ticks → MAIN_YELLOW on the next tick (saturated counter), not 4 ticks later.
- `ped_button` 1-cycle pulse at tick 1, `side_car` = 0, macro defined → SIDE_GREEN reached with `walk` = 1 for its 3 ticks. `walk` = 0 in all other phases.
- Same stimulus, macro undefined → main stays green indefinitely and `walk` stays 0.
- `controller_reset` pulsed mid-SIDE_GREEN with `ped_button` held → next cycle `main_light` = 001, `side_light` = 100, `walk` = 0. Latch re-sets after reset release.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types and constants for the two-road traffic light controller.
package traffic_pkg;

  localparam int unsigned PHASE_CNT_W = 8;

  typedef enum logic [2:0] {
    MainGreen  = 3'd0,
    MainYellow = 3'd1,
    AllRedA    = 3'd2,
    SideGreen  = 3'd3,
    SideYellow = 3'd4,
    AllRedB    = 3'd5
  } phase_e;

  // Lamp encoding is one-hot {red, yellow, green}.
  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

endpackage

// File: rtl/phase_timer.sv
// Per-phase seconds counter: counts second_tick pulses, saturates at limit-1,
// and flags the tick that ends the phase.
module phase_timer
  import traffic_pkg::*;
(
  input  logic                   clk,
  input  logic                   controller_reset,
  input  logic                   second_tick,
  input  logic                   clear,
  input  logic [PHASE_CNT_W-1:0] limit,
  output logic                   expired
);

  logic [PHASE_CNT_W-1:0] phase_cnt_q, phase_cnt_d;
  logic [PHASE_CNT_W-1:0] last_cnt;
  logic                   at_last;

  always_comb begin
    last_cnt    = limit - PHASE_CNT_W'(1);
    at_last     = (phase_cnt_q == last_cnt);
    expired     = at_last & second_tick;
    phase_cnt_d = phase_cnt_q;
    if (clear) begin
      phase_cnt_d = '0;
    end else if (second_tick && !at_last) begin
      phase_cnt_d = phase_cnt_q + PHASE_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (controller_reset) begin
      phase_cnt_q <= '0;
    end else begin
      phase_cnt_q <= phase_cnt_d;
    end
  end

endmodule

// File: rtl/traffic_light_fsm.sv
// Two-road intersection controller driven by the one-second divider pulse.
// Optional pedestrian request/walk lamp enabled by TRAFFIC_PED_REQUEST_EN.
module traffic_light_fsm
  import traffic_pkg::*;
#(
  parameter int unsigned MAIN_GREEN_S = 20,
  parameter int unsigned SIDE_GREEN_S = 10,
  parameter int unsigned YELLOW_S     = 3,
  parameter int unsigned ALL_RED_S    = 1
) (
  input  logic       clk,
  input  logic       controller_reset,
  input  logic       second_tick,
  input  logic       side_car,
  input  logic       ped_button,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk,
  output logic       timer_restart
);

  localparam logic [PHASE_CNT_W-1:0] MainLimit   = PHASE_CNT_W'(MAIN_GREEN_S);
  localparam logic [PHASE_CNT_W-1:0] SideLimit   = PHASE_CNT_W'(SIDE_GREEN_S);
  localparam logic [PHASE_CNT_W-1:0] YellowLimit = PHASE_CNT_W'(YELLOW_S);
  localparam logic [PHASE_CNT_W-1:0] AllRedLimit = PHASE_CNT_W'(ALL_RED_S);

  phase_e                 state_q, state_d;
  logic [PHASE_CNT_W-1:0] limit;
  logic                   expired;
  logic                   advance;
  logic                   enter_side;
  logic                   ped_req;
  logic                   walk_en;
  logic                   timer_restart_q;

  phase_timer u_phase_timer (
    .clk              (clk),
    .controller_reset (controller_reset),
    .second_tick      (second_tick),
    .clear            (advance),
    .limit            (limit),
    .expired          (expired)
  );

  always_comb begin
    state_d = state_q;
    limit   = MainLimit;
    unique case (state_q)
      MainGreen: begin
        limit = MainLimit;
        if (expired && (side_car || ped_req)) state_d = MainYellow;
      end
      MainYellow: begin
        limit = YellowLimit;
        if (expired) state_d = AllRedA;
      end
      AllRedA: begin
        limit = AllRedLimit;
        if (expired) state_d = SideGreen;
      end
      SideGreen: begin
        limit = SideLimit;
        if (expired) state_d = SideYellow;
      end
      SideYellow: begin
        limit = YellowLimit;
        if (expired) state_d = AllRedB;
      end
      AllRedB: begin
        limit = AllRedLimit;
        if (expired) state_d = MainGreen;
      end
      default: state_d = MainGreen;
    endcase
    advance    = (state_d != state_q);
    enter_side = advance && (state_d == SideGreen);
  end

  always_ff @(posedge clk) begin
    if (controller_reset) begin
      state_q <= MainGreen;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef TRAFFIC_PED_REQUEST_EN
  logic ped_req_q, walk_en_q;

  // A press in the same cycle as SIDE_GREEN entry keeps the request pending.
  always_ff @(posedge clk) begin
    if (controller_reset) begin
      ped_req_q <= 1'b0;
      walk_en_q <= 1'b0;
    end else begin
      if (ped_button) begin
        ped_req_q <= 1'b1;
      end else if (enter_side) begin
        ped_req_q <= 1'b0;
      end
      if (enter_side) walk_en_q <= ped_req_q;
    end
  end

  assign ped_req = ped_req_q;
  assign walk_en = walk_en_q;
`else
  logic unused_ped_button;
  assign unused_ped_button = ped_button;
  assign ped_req           = 1'b0;
  assign walk_en           = 1'b0;
`endif

  always_comb begin
    main_light = LAMP_RED;
    side_light = LAMP_RED;
    unique case (state_q)
      MainGreen:  main_light = LAMP_GREEN;
      MainYellow: main_light = LAMP_YELLOW;
      SideGreen:  side_light = LAMP_GREEN;
      SideYellow: side_light = LAMP_YELLOW;
      default: begin
        main_light = LAMP_RED;
        side_light = LAMP_RED;
      end
    endcase
    walk = (state_q == SideGreen) && walk_en;
  end

  // Holds the divider in reset alongside us so the first second is a full one.
  always_ff @(posedge clk) begin
    timer_restart_q <= controller_reset;
  end

  assign timer_restart = timer_restart_q;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Self-checking bench for traffic_light_fsm: per-tick vector tables plus
// hand-written reset, back-to-back tick and pedestrian sequences.
module tb_traffic_light_fsm;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic       clk = 1'b0;
  logic       controller_reset = 1'b1;
  logic       second_tick = 1'b0;
  logic       side_car = 1'b0;
  logic       ped_button = 1'b0;
  logic [2:0] main_light, side_light;
  logic       walk, timer_restart;
  bit         mon_en = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string      name;
    logic [2:0] m;
    logic [2:0] s;
    logic       w;
  } exp_t;

  typedef struct {
    logic       sc;
    logic       pb;
    logic [2:0] m;
    logic [2:0] s;
    logic       w;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];

  traffic_light_fsm #(
    .MAIN_GREEN_S (4),
    .SIDE_GREEN_S (3),
    .YELLOW_S     (2),
    .ALL_RED_S    (1)
  ) dut (
    .clk              (clk),
    .controller_reset (controller_reset),
    .second_tick      (second_tick),
    .side_car         (side_car),
    .ped_button       (ped_button),
    .main_light       (main_light),
    .side_light       (side_light),
    .walk             (walk),
    .timer_restart    (timer_restart)
  );

  always #5 clk = ~clk;

  // Safety invariants checked on every sampled cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      n_cmp++;
      if (!$onehot(main_light) || !$onehot(side_light) ||
          (main_light != R && side_light != R) || (walk && side_light != G)) begin
        n_bad++;
        $display("FAIL invariant @%0t: main=%b side=%b walk=%b", $time, main_light,
                 side_light, walk);
      end
    end
  end

  task automatic push(input string name, input logic [2:0] m, input logic [2:0] s,
                      input logic w);
    exp_t e;
    e.name = name;
    e.m    = m;
    e.s    = s;
    e.w    = w;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if ({main_light, side_light, walk} !== {e.m, e.s, e.w}) begin
        n_bad++;
        $display("FAIL %s: got main=%b side=%b walk=%b, want main=%b side=%b walk=%b",
                 e.name, main_light, side_light, walk, e.m, e.s, e.w);
      end
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %b, want %b", name, got, want);
    end
  endtask

  // One clock: drive at negedge, DUT updates at posedge, compare at next negedge.
  task automatic cyc(input logic tk);
    second_tick = tk;
    @(negedge clk);
    second_tick = 1'b0;
    drain();
  endtask

  task automatic do_reset(input int n, input logic tk_during);
    controller_reset = 1'b1;
    second_tick      = tk_during;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_bit("timer_restart_in_reset", timer_restart, 1'b1);
      push("reset_lamps", G, R, 1'b0);
      drain();
    end
    controller_reset = 1'b0;
    second_tick      = 1'b0;
    @(negedge clk);
    check_bit("timer_restart_released", timer_restart, 1'b0);
  endtask

  // Each vector: one tick (ped_button pulsed with it), lamps checked the cycle
  // after the tick and again at the end of the 5-cycle period.
  task automatic run_table(input string name);
    for (int i = 0; i < tbl.size(); i++) begin
      side_car   = tbl[i].sc;
      ped_button = tbl[i].pb;
      push($sformatf("%s_t%0d", name, i + 1), tbl[i].m, tbl[i].s, tbl[i].w);
      cyc(1'b1);
      ped_button = 1'b0;
      for (int k = 0; k < 3; k++) cyc(1'b0);
      push($sformatf("%s_t%0d_hold", name, i + 1), tbl[i].m, tbl[i].s, tbl[i].w);
      cyc(1'b0);
    end
    tbl.delete();
  endtask

  task automatic add(input logic sc, input logic pb, input logic [2:0] m,
                     input logic [2:0] s, input logic w);
    vec_t v;
    v.sc = sc;
    v.pb = pb;
    v.m  = m;
    v.s  = s;
    v.w  = w;
    tbl.push_back(v);
  endtask

  task automatic add_side_cycle();
    for (int i = 0; i < 3; i++) add(1'b1, 1'b0, G, R, 1'b0);
    add(1'b1, 1'b0, Y, R, 1'b0);
    add(1'b1, 1'b0, Y, R, 1'b0);
    add(1'b1, 1'b0, R, R, 1'b0);
    add(1'b1, 1'b0, R, G, 1'b0);
  endtask

  initial begin
    @(negedge clk);
    mon_en = 1'b1;

    // Idle main road: 10 ticks, no requests; two-cycle reset.
    do_reset(2, 1'b0);
    for (int i = 0; i < 10; i++) add(1'b0, 1'b0, G, R, 1'b0);
    run_table("idle");

    // Full cycle with side_car held; tick during reset must not count.
    do_reset(1, 1'b1);
    add_side_cycle();
    add(1'b1, 1'b0, R, G, 1'b0);
    add(1'b1, 1'b0, R, G, 1'b0);
    add(1'b1, 1'b0, R, Y, 1'b0);
    add(1'b1, 1'b0, R, Y, 1'b0);
    add(1'b1, 1'b0, R, R, 1'b0);
    add(1'b1, 1'b0, G, R, 1'b0);
    run_table("side");

    // Late request: counter saturated, so exit on the very next tick.
    side_car = 1'b0;
    do_reset(1, 1'b0);
    for (int i = 0; i < 7; i++) add(1'b0, 1'b0, G, R, 1'b0);
    add(1'b1, 1'b0, Y, R, 1'b0);
    run_table("late");

    // Back-to-back ticks each count.
    side_car = 1'b0;
    do_reset(1, 1'b0);
    side_car = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push($sformatf("b2b_%0d", i + 1), G, R, 1'b0);
      cyc(1'b1);
    end
    push("b2b_4", Y, R, 1'b0);
    cyc(1'b1);
    side_car = 1'b0;

    // Pedestrian pulse at tick 1 with no side car.
    do_reset(1, 1'b0);
    add(1'b0, 1'b1, G, R, 1'b0);
    add(1'b0, 1'b0, G, R, 1'b0);
    add(1'b0, 1'b0, G, R, 1'b0);
`ifdef TRAFFIC_PED_REQUEST_EN
    add(1'b0, 1'b0, Y, R, 1'b0);
    add(1'b0, 1'b0, Y, R, 1'b0);
    add(1'b0, 1'b0, R, R, 1'b0);
    for (int i = 0; i < 3; i++) add(1'b0, 1'b0, R, G, 1'b1);
    add(1'b0, 1'b0, R, Y, 1'b0);
    add(1'b0, 1'b0, R, Y, 1'b0);
    add(1'b0, 1'b0, R, R, 1'b0);
    for (int i = 0; i < 4; i++) add(1'b0, 1'b0, G, R, 1'b0);
`else
    for (int i = 0; i < 13; i++) add(1'b0, 1'b0, G, R, 1'b0);
`endif
    run_table("ped");

    // Reset mid-SIDE_GREEN with ped_button held.
    do_reset(1, 1'b0);
    add_side_cycle();
    add(1'b1, 1'b0, R, G, 1'b0);
    run_table("pre_rst");
    side_car   = 1'b0;
    ped_button = 1'b1;
    push("ped_in_side_green", R, G, 1'b0);
    cyc(1'b0);
    controller_reset = 1'b1;
    push("mid_reset_lamps", G, R, 1'b0);
    cyc(1'b1);
    check_bit("mid_reset_timer_restart", timer_restart, 1'b1);
    controller_reset = 1'b0;
    cyc(1'b0);
    check_bit("mid_reset_timer_released", timer_restart, 1'b0);
    cyc(1'b0);
    ped_button = 1'b0;
    for (int i = 0; i < 3; i++) add(1'b0, 1'b0, G, R, 1'b0);
`ifdef TRAFFIC_PED_REQUEST_EN
    add(1'b0, 1'b0, Y, R, 1'b0);
`else
    add(1'b0, 1'b0, G, R, 1'b0);
`endif
    run_table("relatch");

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
